// File: rtl/pcie_cpl_rx.sv
`default_nettype none
// ============================================================================
// Module   : pcie_cpl_rx
// Brief    : DMA read completion receiver. Tracks read tags, checks status,
//            strips the 3DW header and realigns CplD payload to DW0.
// Revision : 1.0 - initial release
// ============================================================================
module pcie_cpl_rx #(
  parameter int P_DATA_WIDTH = 128,
  parameter int P_KEEP_WIDTH = P_DATA_WIDTH / 8,
  parameter int TAG_BITS     = 5
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [P_DATA_WIDTH-1:0] m_axis_rx_tdata,
  input  logic [P_KEEP_WIDTH-1:0] m_axis_rx_tkeep,
  input  logic                    m_axis_rx_tlast,
  input  logic                    m_axis_rx_tvalid,
  output logic                    m_axis_rx_tready,
  input  logic [7:0]              issue_tag,
  input  logic                    issue_valid,
  output logic [P_DATA_WIDTH-1:0] cpl_data,
  output logic [3:0]              cpl_keep,
  output logic [7:0]              cpl_tag,
  output logic                    cpl_last,
  output logic                    cpl_valid,
  input  logic                    cpl_ready,
  output logic                    cpl_done,
  output logic                    cpl_error,
  output logic [TAG_BITS:0]       outstanding,
  output logic                    drop
);

  localparam int         c_NTAGS    = 1 << TAG_BITS;
  localparam logic [6:0] c_FMT_CPL  = 7'h0A;
  localparam logic [6:0] c_FMT_CPLD = 7'h4A;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STREAM  = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_DISCARD = 2'd3
  } state_t;

  state_t r_state, w_state_next;

  logic [P_DATA_WIDTH-1:0] r_cpl_data;
  logic [3:0]              r_cpl_keep;
  logic [7:0]              r_cpl_tag;
  logic                    r_cpl_last, r_cpl_valid, r_out_final;
  logic                    r_cpl_done, r_cpl_error, r_drop;
  logic [31:0]             r_scratch;
  logic [10:0]             r_rem;
  logic [7:0]              r_tag;
  logic                    r_final;
  logic [c_NTAGS-1:0]      r_bitmap, w_bitmap_next;
  logic [TAG_BITS:0]       r_outstanding, w_count_next;

  logic                    w_slot_free, w_accept;
  logic [6:0]              w_fmt_type;
  logic                    w_ep, w_is_cpl, w_tag_hit, w_final;
  logic [9:0]              w_len_raw;
  logic [10:0]             w_len;
  logic [2:0]              w_status;
  logic [11:0]             w_bc;
  logic [7:0]              w_tag;
  logic                    w_emit, w_emit_last, w_emit_final;
  logic [P_DATA_WIDTH-1:0] w_emit_data;
  logic [3:0]              w_emit_keep;
  logic                    w_hdr_load, w_advance, w_drop, w_err, w_clr_err, w_clr_out;
  logic                    w_unused;

  assign w_unused = &{1'b0, m_axis_rx_tkeep, issue_tag[7:TAG_BITS]};

  assign w_slot_free      = !r_cpl_valid || cpl_ready;
  assign m_axis_rx_tready = !i_rst && ((r_state == ST_DISCARD) ||
                                       ((r_state != ST_FLUSH) && w_slot_free));
  assign w_accept         = m_axis_rx_tvalid && m_axis_rx_tready;

  assign w_fmt_type = m_axis_rx_tdata[30:24];
  assign w_ep       = m_axis_rx_tdata[14];
  assign w_len_raw  = m_axis_rx_tdata[9:0];
  assign w_status   = m_axis_rx_tdata[47:45];
  assign w_bc       = m_axis_rx_tdata[43:32];
  assign w_tag      = m_axis_rx_tdata[79:72];
  assign w_len      = (w_len_raw == 10'd0) ? 11'd1024 : {1'b0, w_len_raw};
  assign w_is_cpl   = (w_fmt_type == c_FMT_CPL) || (w_fmt_type == c_FMT_CPLD);
  assign w_tag_hit  = r_bitmap[w_tag[TAG_BITS-1:0]];
  // A completion is the last one for its tag once remaining bytes fit in it.
  assign w_final    = ({1'b0, w_bc} <= {w_len, 2'b00});

  function automatic logic [3:0] f_keep(input logic [10:0] rem);
    if (rem >= 11'd4)       return 4'b1111;
    else if (rem == 11'd3)  return 4'b0111;
    else if (rem == 11'd2)  return 4'b0011;
    else                    return 4'b0001;
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_emit       = 1'b0;
    w_emit_data  = '0;
    w_emit_keep  = 4'b0000;
    w_emit_last  = 1'b0;
    w_emit_final = 1'b0;
    w_hdr_load   = 1'b0;
    w_advance    = 1'b0;
    w_drop       = 1'b0;
    w_err        = 1'b0;
    w_clr_err    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (!w_is_cpl) begin
            w_drop = 1'b1;
            if (!m_axis_rx_tlast) w_state_next = ST_DISCARD;
          end else if (!w_tag_hit) begin
            w_err = 1'b1;
            if (!m_axis_rx_tlast) w_state_next = ST_DISCARD;
          end else if ((w_status != 3'd0) || w_ep || (w_fmt_type == c_FMT_CPL)) begin
            w_err     = 1'b1;
            w_clr_err = 1'b1;
            if (!m_axis_rx_tlast) w_state_next = ST_DISCARD;
          end else begin
            w_hdr_load = 1'b1;
            if (w_len == 11'd1) begin
              w_emit       = 1'b1;
              w_emit_data  = {96'b0, m_axis_rx_tdata[127:96]};
              w_emit_keep  = 4'b0001;
              w_emit_last  = 1'b1;
              w_emit_final = w_final;
              if (!m_axis_rx_tlast) w_state_next = ST_DISCARD;
            end else if (!m_axis_rx_tlast) begin
              w_state_next = ST_STREAM;
            end
          end
        end
      end
      ST_STREAM: begin
        if (w_accept) begin
          w_emit       = 1'b1;
          w_emit_data  = {m_axis_rx_tdata[95:0], r_scratch};
          w_emit_keep  = f_keep(r_rem);
          w_emit_last  = (r_rem <= 11'd4);
          w_emit_final = r_final;
          w_advance    = 1'b1;
          // rem == 5 leaves exactly one DW in scratch after this beat.
          if (m_axis_rx_tlast)      w_state_next = (r_rem == 11'd5) ? ST_FLUSH : ST_IDLE;
          else if (r_rem <= 11'd4)  w_state_next = ST_DISCARD;
        end
      end
      ST_FLUSH: begin
        if (w_slot_free) begin
          w_emit       = 1'b1;
          w_emit_data  = {96'b0, r_scratch};
          w_emit_keep  = 4'b0001;
          w_emit_last  = 1'b1;
          w_emit_final = r_final;
          w_state_next = ST_IDLE;
        end
      end
      ST_DISCARD: begin
        if (w_accept && m_axis_rx_tlast) w_state_next = ST_IDLE;
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_scratch <= '0;
      r_rem     <= '0;
      r_tag     <= '0;
      r_final   <= 1'b0;
    end else if (w_hdr_load) begin
      r_scratch <= m_axis_rx_tdata[127:96];
      r_rem     <= w_len;
      r_tag     <= w_tag;
      r_final   <= w_final;
    end else if (w_advance) begin
      r_scratch <= m_axis_rx_tdata[127:96];
      r_rem     <= (r_rem > 11'd4) ? (r_rem - 11'd4) : 11'd0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cpl_valid <= 1'b0;
      r_cpl_last  <= 1'b0;
      r_cpl_data  <= '0;
      r_cpl_keep  <= 4'b0000;
      r_cpl_tag   <= 8'd0;
      r_out_final <= 1'b0;
    end else if (w_emit) begin
      r_cpl_valid <= 1'b1;
      r_cpl_last  <= w_emit_last;
      r_cpl_data  <= w_emit_data;
      r_cpl_keep  <= w_emit_keep;
      r_cpl_tag   <= w_hdr_load ? w_tag : r_tag;
      r_out_final <= w_emit_final;
    end else if (cpl_ready) begin
      r_cpl_valid <= 1'b0;
    end
  end

  assign w_clr_out = r_cpl_valid && cpl_ready && r_cpl_last && r_out_final;

  // Set is applied after both clears so a same-cycle reissue keeps the tag.
  always_comb begin
    w_bitmap_next = r_bitmap;
    if (w_clr_out)   w_bitmap_next[r_cpl_tag[TAG_BITS-1:0]] = 1'b0;
    if (w_clr_err)   w_bitmap_next[w_tag[TAG_BITS-1:0]]     = 1'b0;
    if (issue_valid) w_bitmap_next[issue_tag[TAG_BITS-1:0]] = 1'b1;
    w_count_next = '0;
    for (int i = 0; i < c_NTAGS; i++)
      w_count_next = w_count_next + {{TAG_BITS{1'b0}}, w_bitmap_next[i]};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bitmap      <= '0;
      r_outstanding <= '0;
      r_cpl_done    <= 1'b0;
      r_cpl_error   <= 1'b0;
      r_drop        <= 1'b0;
    end else begin
      r_bitmap      <= w_bitmap_next;
      r_outstanding <= w_count_next;
      r_cpl_done    <= w_clr_out || w_clr_err;
      r_cpl_error   <= w_err;
      r_drop        <= w_drop;
    end
  end

  assign cpl_data    = r_cpl_data;
  assign cpl_keep    = r_cpl_keep;
  assign cpl_tag     = r_cpl_tag;
  assign cpl_last    = r_cpl_last;
  assign cpl_valid   = r_cpl_valid;
  assign cpl_done    = r_cpl_done;
  assign cpl_error   = r_cpl_error;
  assign drop        = r_drop;
  assign outstanding = r_outstanding;

endmodule
`default_nettype wire

// File: tb/tb_pcie_cpl_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_pcie_cpl_rx
// Brief    : Scoreboard bench for pcie_cpl_rx completion receiver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcie_cpl_rx;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic [127:0] m_axis_rx_tdata;
  logic [15:0]  m_axis_rx_tkeep;
  logic         m_axis_rx_tlast;
  logic         m_axis_rx_tvalid;
  logic         m_axis_rx_tready;
  logic [7:0]   issue_tag;
  logic         issue_valid;
  logic [127:0] cpl_data;
  logic [3:0]   cpl_keep;
  logic [7:0]   cpl_tag;
  logic         cpl_last, cpl_valid, cpl_ready, cpl_done, cpl_error, drop;
  logic [5:0]   outstanding;

  always #5 i_clk = ~i_clk;

  pcie_cpl_rx dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .m_axis_rx_tdata(m_axis_rx_tdata), .m_axis_rx_tkeep(m_axis_rx_tkeep),
    .m_axis_rx_tlast(m_axis_rx_tlast), .m_axis_rx_tvalid(m_axis_rx_tvalid),
    .m_axis_rx_tready(m_axis_rx_tready),
    .issue_tag(issue_tag), .issue_valid(issue_valid),
    .cpl_data(cpl_data), .cpl_keep(cpl_keep), .cpl_tag(cpl_tag),
    .cpl_last(cpl_last), .cpl_valid(cpl_valid), .cpl_ready(cpl_ready),
    .cpl_done(cpl_done), .cpl_error(cpl_error),
    .outstanding(outstanding), .drop(drop)
  );

  typedef struct {
    logic [127:0] data;
    logic [3:0]   keep;
    logic [7:0]   tag;
    logic         last;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0, n_fail = 0;
  int   n_done = 0, n_err = 0, n_drop = 0;
  int   exp_done = 0, exp_err = 0, exp_drop = 0, exp_out = 0;
  logic         prev_stall = 1'b0;
  logic [127:0] prev_data  = '0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, act, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (i_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (cpl_done)  n_done++;
      if (cpl_error) n_err++;
      if (drop)      n_drop++;
      if (prev_stall) begin
        if (!cpl_valid) check("beat_lost_in_stall", 0, 1);
        else            check("stall_data_stable", cpl_data, prev_data);
      end
      if (cpl_valid && cpl_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          check("beat_data", cpl_data, mon_e.data);
          check("beat_keep", cpl_keep, mon_e.keep);
          check("beat_tag",  cpl_tag,  mon_e.tag);
          check("beat_last", cpl_last, mon_e.last);
        end
      end
      prev_stall = cpl_valid && !cpl_ready;
      prev_data  = cpl_data;
    end
  end

  task automatic send_beat(input logic [127:0] d, input logic last);
    bit ok;
    int n = 0;
    m_axis_rx_tdata  = d;
    m_axis_rx_tlast  = last;
    m_axis_rx_tvalid = 1'b1;
    do begin
      @(negedge i_clk);
      ok = m_axis_rx_tready;
      @(posedge i_clk);
      n++;
    end while (!ok && n < 200);
    if (!ok) check("tready_timeout", 0, 1);
    #1;
    m_axis_rx_tvalid = 1'b0;
    m_axis_rx_tlast  = 1'b0;
  endtask

  // Builds a 3DW-header TLP, pushes the DW0-aligned payload beats that the
  // sink should see, then drives the TLP beat by beat.
  task automatic send_tlp(input logic [6:0] fmt, input logic [7:0] tag, input int len,
                          input int npl, input logic [11:0] bc, input logic [2:0] st,
                          input logic ep, input logic [31:0] dw_first, input bit exp_beats);
    logic [31:0]  dws[$];
    logic [31:0]  h;
    logic [127:0] d;
    exp_t         x;
    int           nb, cnt, idx;
    h = '0; h[30:24] = fmt; h[14] = ep; h[9:0] = len[9:0]; dws.push_back(h);
    h = '0; h[15:13] = st;  h[11:0] = bc;                   dws.push_back(h);
    h = '0; h[15:8]  = tag;                                 dws.push_back(h);
    for (int i = 0; i < npl; i++) dws.push_back((i == 0) ? dw_first : $urandom);
    if (exp_beats) begin
      nb = (len + 3) / 4;
      for (int b = 0; b < nb; b++) begin
        x.data = '0;
        for (int k = 0; k < 4; k++) begin
          idx = 4 * b + k;
          if (idx < len) x.data[32*k +: 32] = dws[3 + idx];
        end
        cnt    = len - 4 * b;
        x.keep = (cnt >= 4) ? 4'b1111 : (cnt == 3) ? 4'b0111 : (cnt == 2) ? 4'b0011 : 4'b0001;
        x.tag  = tag;
        x.last = (b == nb - 1);
        sb_q.push_back(x);
      end
    end
    nb = (dws.size() + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      d = '0;
      for (int k = 0; k < 4; k++)
        if (4 * b + k < dws.size()) d[32*k +: 32] = dws[4 * b + k];
      send_beat(d, b == nb - 1);
    end
  endtask

  task automatic issue(input logic [7:0] t);
    issue_tag   = t;
    issue_valid = 1'b1;
    @(posedge i_clk);
    #1;
    issue_valid = 1'b0;
  endtask

  task automatic settle();
    int n = 0;
    while ((sb_q.size() != 0 || cpl_valid) && n < 300) begin
      @(posedge i_clk);
      n++;
    end
    if (n >= 300) check("drain_timeout", 0, 1);
    repeat (3) @(posedge i_clk);
    #1;
    check("done_count",  n_done,  exp_done);
    check("error_count", n_err,   exp_err);
    check("drop_count",  n_drop,  exp_drop);
    check("outstanding", outstanding, exp_out);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [127:0] d;
    i_rst = 1'b1; m_axis_rx_tdata = '0; m_axis_rx_tkeep = 16'hFFFF;
    m_axis_rx_tlast = 1'b0; m_axis_rx_tvalid = 1'b0;
    issue_tag = 8'd0; issue_valid = 1'b0; cpl_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check("rst_tready", m_axis_rx_tready, 0);
    check("rst_valid",  cpl_valid, 0);
    check("rst_last",   cpl_last, 0);
    check("rst_outstanding", outstanding, 0);
    @(posedge i_clk); #1; i_rst = 1'b0;
    @(negedge i_clk);
    check("tready_after_rst", m_axis_rx_tready, 1);
    @(posedge i_clk); #1;

    // single-DW completion
    issue(8'd3);
    @(negedge i_clk); check("outstanding_after_issue", outstanding, 1);
    @(posedge i_clk); #1;
    send_tlp(7'h4A, 8'd3, 1, 1, 12'd4, 3'd0, 1'b0, 32'hA5A5A5A5, 1);
    exp_done++; settle();

    // len 8, exact multiple, no flush
    issue(8'd1);
    send_tlp(7'h4A, 8'd1, 8, 8, 12'd32, 3'd0, 1'b0, $urandom, 1);
    exp_done++; settle();

    // len 5 needs a flush beat; tready drops for one cycle
    issue(8'd2);
    send_tlp(7'h4A, 8'd2, 5, 5, 12'd20, 3'd0, 1'b0, $urandom, 1);
    @(negedge i_clk); check("flush_tready_low", m_axis_rx_tready, 0);
    @(negedge i_clk); check("flush_tready_back", m_axis_rx_tready, 1);
    @(posedge i_clk); #1;
    exp_done++; settle();

    // split completion: first part not final
    issue(8'd4); exp_out = 1;
    send_tlp(7'h4A, 8'd4, 16, 16, 12'd128, 3'd0, 1'b0, $urandom, 1);
    settle();
    send_tlp(7'h4A, 8'd4, 16, 16, 12'd64, 3'd0, 1'b0, $urandom, 1);
    exp_done++; exp_out = 0; settle();

    // Cpl with UR status on outstanding tag
    issue(8'd5);
    send_tlp(7'h0A, 8'd5, 0, 0, 12'd4, 3'd1, 1'b0, 32'h0, 0);
    exp_err++; exp_done++; settle();

    // CplD on an unissued tag leaves the bitmap alone
    issue(8'd6); exp_out = 1;
    send_tlp(7'h4A, 8'd9, 4, 4, 12'd16, 3'd0, 1'b0, $urandom, 0);
    exp_err++; settle();

    // non-completion TLP
    send_tlp(7'h40, 8'd0, 8, 8, 12'd0, 3'd0, 1'b0, $urandom, 0);
    exp_drop++; settle();

    // reissuing an outstanding tag does not recount it
    issue(8'd6); settle();

    // sink back-pressure mid-stream
    issue(8'd7); exp_out = 2;
    fork
      send_tlp(7'h4A, 8'd7, 16, 16, 12'd64, 3'd0, 1'b0, $urandom, 1);
      begin
        int n = 0;
        while (!cpl_valid && n < 100) begin @(negedge i_clk); n++; end
        if (n >= 100) check("stall_wait_timeout", 0, 1);
        @(posedge i_clk); #1; cpl_ready = 1'b0;
        repeat (5) begin
          @(negedge i_clk);
          check("stall_tready_low", m_axis_rx_tready, 0);
        end
        @(posedge i_clk); #1; cpl_ready = 1'b1;
      end
    join
    exp_done++; exp_out = 1; settle();

    // len 3: partial keep in one beat
    issue(8'd10);
    send_tlp(7'h4A, 8'd10, 3, 3, 12'd12, 3'd0, 1'b0, $urandom, 1);
    exp_done++; settle();

    // reset in the middle of a stream
    issue(8'd8); exp_out = 2; settle();
    d = '0; d[30:24] = 7'h4A; d[9:0] = 10'd16; d[43:32] = 12'd64; d[79:72] = 8'd8;
    d[127:96] = 32'h11111111;
    send_beat(d, 1'b0);
    send_beat({4{32'h22222222}}, 1'b0);
    i_rst = 1'b1;
    @(posedge i_clk); @(negedge i_clk);
    check("midrst_tready", m_axis_rx_tready, 0);
    check("midrst_valid",  cpl_valid, 0);
    check("midrst_last",   cpl_last, 0);
    check("midrst_done",   cpl_done, 0);
    check("midrst_error",  cpl_error, 0);
    check("midrst_drop",   drop, 0);
    check("midrst_outstanding", outstanding, 0);
    @(posedge i_clk); #1; i_rst = 1'b0; exp_out = 0;
    @(posedge i_clk); #1;

    // recovery after reset
    issue(8'd3);
    send_tlp(7'h4A, 8'd3, 1, 1, 12'd4, 3'd0, 1'b0, 32'h5A5A5A5A, 1);
    exp_done++; settle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pcie_cpl_rx.md
Name: pcie_cpl_rx

Overview:
- Receive-side completion engine for the DMA read path.
- Consumes completion TLPs from the PCIe core's 128-bit RX AXI-Stream (m_axis_rx_*) for reads issued by the TX engine.
- Tracks outstanding read tags, checks completion status, strips the 3DW header and realigns the payload into DW0-aligned 128-bit beats for the DMA read data sink.

Parameters:
P_DATA_WIDTH, 128, AXIS data width; only 128 is supported.
P_KEEP_WIDTH, P_DATA_WIDTH/8, AXIS byte-keep width.
TAG_BITS, 5, tracked tag bits; tags are used modulo 2^TAG_BITS.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous, active-high reset
m_axis_rx_tdata  in  128  RX TLP data; TLPs start at DW0 of a beat, no straddling
m_axis_rx_tkeep  in  16  byte keep; informational only
m_axis_rx_tlast  in  1  last beat of TLP
m_axis_rx_tvalid  in  1  RX beat valid
m_axis_rx_tready  out  1  RX beat accepted
issue_tag  in  8  tag of a newly issued read request
issue_valid  in  1  1-cycle pulse: issue_tag becomes outstanding
cpl_data  out  128  realigned payload; DW0 in [31:0]
cpl_keep  out  4  per-DW valid mask, contiguous from DW0
cpl_tag  out  8  tag of the completion being output
cpl_last  out  1  final output beat of this completion TLP
cpl_valid  out  1  output beat valid
cpl_ready  in  1  sink accepts output beat
cpl_done  out  1  pulse: final completion for a tag received, tag freed
cpl_error  out  1  pulse: non-SC status, EP=1, or unexpected tag
outstanding  out  TAG_BITS+1  count of outstanding tags
drop  out  1  pulse: non-completion TLP discarded

Behaviour:
- Reset: m_axis_rx_tready=0, cpl_valid=0, cpl_last=0, cpl_done=0, cpl_error=0, drop=0, outstanding=0, tag bitmap cleared, state IDLE. A reset mid-TLP abandons the TLP; the core is reset together with this block.
- Header fields, first beat:
  - fmt_type = DW0[30:24]; 0x4A = CplD, 0x0A = Cpl.
  - EP = DW0[14]; len = DW0[9:0], where 0 means 1024.
  - status = DW1[15:13]; byte_count = DW1[11:0].
  - tag = DW2[15:8].
  - First payload DW = DW3.
- m_axis_rx_tready = (state != FLUSH) && (!cpl_valid || cpl_ready). In DISCARD it is 1.
- IDLE, on an accepted beat:
  - fmt_type not 0x0A/0x4A: pulse drop; go to DISCARD unless tlast.
  - Tag not outstanding: pulse cpl_error; DISCARD unless tlast; bitmap unchanged.
  - status != 0, EP=1, or Cpl: pulse cpl_error and cpl_done; clear tag; DISCARD unless tlast.
  - Valid CplD: scratch = DW3, rem = len.
    - len == 1: emit {96'b0, DW3}, keep=0001, last=1.
    - Otherwise go to STREAM.
  - Final-completion test: byte_count <= len*4, using a 13-bit compare. When true, the tag is cleared and cpl_done pulses when the last output beat is accepted.
- STREAM, per accepted beat:
  - Emit {in[95:0], scratch} with keep = 4 DWs masked to min(rem,4).
  - last = (rem <= 4).
  - scratch <= in[127:96]; rem <= rem - 4.
  - If tlast and rem_after == 1, go to FLUSH; else if tlast, go to IDLE.
- FLUSH: emit {96'b0, scratch}, keep=0001, last=1, when the output slot is free; then go to IDLE.
- DISCARD: consume beats until tlast, then go to IDLE.
- Output register:
  - cpl_valid holds with stable data until cpl_ready.
  - Output appears 1 cycle after the input beat supplying its last DW.
  - FLUSH adds 1 cycle.
- Tag bitmap and counter:
  - issue_valid sets bit issue_tag[TAG_BITS-1:0] and increments outstanding.
  - Issuing an already-set tag leaves the bitmap unchanged and does not increment outstanding.
  - Same-cycle issue and clear: if the tags differ, both apply and the count is unchanged. If the tags are equal, set wins and the count is unchanged.
- cpl_tag is held for every beat of the TLP.

Test Plan:
- Issue tag 3; CplD len=1, bc=4, DW3=0xA5A5A5A5 -> one beat, data[31:0]=0xA5A5A5A5, keep=0001, last=1, cpl_done=1, outstanding 1->0.
- Tag 1, CplD len=8, bc=32, 3 beats -> 2 output beats, both keep=1111, second last=1; beat2 data = {b3[95:0], b2[127:96]}; no FLUSH.
- Tag 2, CplD len=5 in 2 beats -> out1 keep=1111, then FLUSH beat keep=0001, last=1; tready low for 1 cycle.
- Tag 4, len=16, bc=128 (split; not final) -> bit 4 stays set, no cpl_done. Second CplD len=16, bc=64 -> cpl_done=1.
- Cpl status=UR on outstanding tag 5 -> cpl_error=1, cpl_done=1, no cpl_valid. CplD on unissued tag 9 -> cpl_error=1, payload dropped, bitmap unchanged.
- MWr TLP (fmt_type 0x40, 3 beats) -> drop=1, no output.
- cpl_ready low for 5 cycles mid-STREAM -> tready low, data stable, no beat lost.
- Assert i_rst mid-STREAM -> all outputs return to reset values next cycle.
